id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage pipelined CPU.
- Captures decoded operands and control from the ID stage and drives the EX-stage operand muxes (ALUSrc/RegDst 2-to-1 selects) and the ALU.
- Supports hold (stall), bubble insertion (flush) and a per-entry valid bit.
- Provides registered-state load-use hazard detection back to the ID stage.

---
 rtl/id_ex_pipe_reg.sv | 139 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, valid gating and load-use hazard detection.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  pc_i,
    input  logic [DATA_W-1:0]  rs_data_i,
    input  logic [DATA_W-1:0]  rt_data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [REG_AW-1:0]  rs_addr_i,
    input  logic [REG_AW-1:0]  rt_addr_i,
    input  logic [REG_AW-1:0]  rd_addr_i,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic               alu_src_i,
    input  logic               reg_dst_i,
    input  logic               branch_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               reg_write_i,
    input  logic               mem_to_reg_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  pc_o,
    output logic [DATA_W-1:0]  rs_data_o,
    output logic [DATA_W-1:0]  rt_data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [REG_AW-1:0]  rs_addr_o,
    output logic [REG_AW-1:0]  rt_addr_o,
    output logic [REG_AW-1:0]  rd_addr_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               alu_src_o,
    output logic               reg_dst_o,
    output logic               branch_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               reg_write_o,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [15:0]        bubble_cnt_o,
`endif
    output logic               mem_to_reg_o,
    output logic               load_use_hazard_o
);

    logic [DATA_W-1:0]  r_pc, r_rs_data, r_rt_data, r_imm;
    logic [REG_AW-1:0]  r_rs_addr, r_rt_addr, r_rd_addr;
    logic [ALUOP_W-1:0] r_alu_op;
    logic               r_valid;
    logic [6:0]         r_ctrl;
    logic [6:0]         w_ctrl_in;
    logic [6:0]         w_ctrl_next;
    logic               w_rt_match;

    assign w_ctrl_in = {alu_src_i, reg_dst_i, branch_i, mem_read_i,
                        mem_write_i, reg_write_i, mem_to_reg_i};
    // An invalid instruction loads its data fields but must not cause side effects.
    assign w_ctrl_next = valid_i ? w_ctrl_in : 7'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_alu_op  <= '0;
            r_ctrl    <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_alu_op  <= '0;
            r_ctrl    <= '0;
        end else if (!stall_i) begin
            r_valid   <= valid_i;
            r_pc      <= pc_i;
            r_rs_data <= rs_data_i;
            r_rt_data <= rt_data_i;
            r_imm     <= imm_i;
            r_rs_addr <= rs_addr_i;
            r_rt_addr <= rt_addr_i;
            r_rd_addr <= rd_addr_i;
            r_alu_op  <= alu_op_i;
            r_ctrl    <= w_ctrl_next;
        end
    end

    assign valid_o      = r_valid;
    assign pc_o         = r_pc;
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign rs_addr_o    = r_rs_addr;
    assign rt_addr_o    = r_rt_addr;
    assign rd_addr_o    = r_rd_addr;
    assign alu_op_o     = r_alu_op;
    assign alu_src_o    = r_ctrl[6];
    assign reg_dst_o    = r_ctrl[5];
    assign branch_o     = r_ctrl[4];
    assign mem_read_o   = r_ctrl[3];
    assign mem_write_o  = r_ctrl[2];
    assign reg_write_o  = r_ctrl[1];
    assign mem_to_reg_o = r_ctrl[0];

    // $0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rt_match = (r_rt_addr == rs_addr_i) || (r_rt_addr == rt_addr_i);
    assign load_use_hazard_o = r_valid && r_ctrl[3] && (r_rt_addr != '0) && w_rt_match;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic        w_bubble;

    assign w_bubble = flush_i || (!stall_i && !valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected entries queued at drive time, checked after the edge.
// Bubble counter checks are compiled in when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
        logic [2:0]  op;
        logic        asrc;
        logic        rdst;
        logic        br;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   stall;
    logic   flush;
    entry_t id_in;
    entry_t obs;
    logic   hz;
    entry_t model;
    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bcnt;
    logic [15:0] bcnt_model;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .flush_i          (flush),
        .valid_i          (id_in.v),
        .pc_i             (id_in.pc),
        .rs_data_i        (id_in.rsd),
        .rt_data_i        (id_in.rtd),
        .imm_i            (id_in.imm),
        .rs_addr_i        (id_in.rsa),
        .rt_addr_i        (id_in.rta),
        .rd_addr_i        (id_in.rda),
        .alu_op_i         (id_in.op),
        .alu_src_i        (id_in.asrc),
        .reg_dst_i        (id_in.rdst),
        .branch_i         (id_in.br),
        .mem_read_i       (id_in.mr),
        .mem_write_i      (id_in.mw),
        .reg_write_i      (id_in.rw),
        .mem_to_reg_i     (id_in.m2r),
        .valid_o          (obs.v),
        .pc_o             (obs.pc),
        .rs_data_o        (obs.rsd),
        .rt_data_o        (obs.rtd),
        .imm_o            (obs.imm),
        .rs_addr_o        (obs.rsa),
        .rt_addr_o        (obs.rta),
        .rd_addr_o        (obs.rda),
        .alu_op_o         (obs.op),
        .alu_src_o        (obs.asrc),
        .reg_dst_o        (obs.rdst),
        .branch_o         (obs.br),
        .mem_read_o       (obs.mr),
        .mem_write_o      (obs.mw),
        .reg_write_o      (obs.rw),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_cnt_o     (bcnt),
`endif
        .mem_to_reg_o     (obs.m2r),
        .load_use_hazard_o(hz)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic entry_t mk(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                                  input logic [31:0] rtd, input logic [31:0] imm,
                                  input logic [4:0] rsa, input logic [4:0] rta,
                                  input logic [4:0] rda, input logic [2:0] op,
                                  input logic [6:0] ctrl);
        entry_t e;
        e.v = v; e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
        e.rsa = rsa; e.rta = rta; e.rda = rda; e.op = op;
        {e.asrc, e.rdst, e.br, e.mr, e.mw, e.rw, e.m2r} = ctrl;
        return e;
    endfunction

    function automatic entry_t next_entry(input entry_t cur, input logic st, input logic fl,
                                          input entry_t e);
        entry_t n;
        if (fl) begin
            n = '0;
        end else if (st) begin
            n = cur;
        end else begin
            n = e;
            if (!e.v) {n.asrc, n.rdst, n.br, n.mr, n.mw, n.rw, n.m2r} = 7'b0;
        end
        return n;
    endfunction

    function automatic logic hz_model(input entry_t s, input logic [4:0] rsa, input logic [4:0] rta);
        return s.v && s.mr && (s.rta != 5'd0) && ((s.rta == rsa) || (s.rta == rta));
    endfunction

    task automatic step(input logic st, input logic fl, input entry_t e);
        entry_t want;
        stall = st;
        flush = fl;
        id_in = e;
        exp_q.push_back(next_entry(model, st, fl, e));
`ifdef ID_EX_BUBBLE_CNT_EN
        if ((fl || (!st && !e.v)) && bcnt_model != 16'hFFFF) bcnt_model = bcnt_model + 16'd1;
`endif
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        model = want;
        check("entry", 160'(obs), 160'(want));
        check("hazard", 160'(hz), 160'(hz_model(model, id_in.rsa, id_in.rta)));
`ifdef ID_EX_BUBBLE_CNT_EN
        check("bubble_cnt", 160'(bcnt), 160'(bcnt_model));
`endif
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
        bcnt_model = 16'd0;
        check("reset_bubble_cnt", 160'(bcnt), 160'd0);
`endif
        check("reset_entry", 160'(obs), 160'd0);
        check("reset_hazard", 160'(hz), 160'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    entry_t a, b, r;

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        id_in = '0;
        model = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
        bcnt_model = 16'd0;
`endif
        #1;
        check("por_entry", 160'(obs), 160'd0);
        check("por_hazard", 160'(hz), 160'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic load.
        a = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFC,
               5'd3, 5'd4, 5'd5, 3'b010, 7'b0000010);
        step(1'b0, 1'b0, a);

        // Stall three edges with changing inputs, then flush+stall.
        for (int i = 0; i < 3; i++) begin
            b = mk(1'b1, 32'h100 + i, 32'hA5A5_0000 + i, 32'h5A5A_0000 + i, 32'h7 + i,
                   5'd9, 5'd10, 5'd11, 3'b111, 7'b1111111);
            step(1'b1, 1'b0, b);
        end
        step(1'b1, 1'b1, b);

        // Load-use: load with rt=8, then ID presents rs=8, then rt=8.
        a = mk(1'b1, 32'h20, 32'h1, 32'h2, 32'h3, 5'd1, 5'd8, 5'd0, 3'b000, 7'b1001001);
        step(1'b0, 1'b0, a);
        b = a; b.rsa = 5'd8; b.rta = 5'd2;
        step(1'b1, 1'b0, b);
        b.rsa = 5'd2; b.rta = 5'd8;
        step(1'b1, 1'b0, b);
        b.rta = 5'd9;
        step(1'b1, 1'b0, b);
        // Load into $0 never hazards.
        a = mk(1'b1, 32'h24, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0, 5'd0, 3'b000, 7'b1001001);
        step(1'b0, 1'b0, a);
        step(1'b1, 1'b0, a);
        // Invalid load: data loads, control forced low, no hazard.
        a = mk(1'b0, 32'h28, 32'h11, 32'h22, 32'h33, 5'd8, 5'd8, 5'd7, 3'b101, 7'b1111111);
        step(1'b0, 1'b0, a);
        step(1'b1, 1'b0, a);

        // Async reset with nonzero, hazarding contents while stall and flush are high.
        a = mk(1'b1, 32'h30, 32'hFFFF_FFFF, 32'h1, 32'h2, 5'd6, 5'd6, 5'd6, 3'b011, 7'b0001000);
        step(1'b0, 1'b0, a);
        stall = 1'b1;
        flush = 1'b1;
        async_reset();
        a.pc = 32'h34;
        step(1'b0, 1'b0, a);

`ifdef ID_EX_BUBBLE_CNT_EN
        async_reset();
        a = mk(1'b1, 32'h40, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 7'b0000010);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, a);
        step(1'b1, 1'b0, a);
        step(1'b1, 1'b0, a);
        a.v = 1'b0;
        step(1'b0, 1'b0, a);
        check("bubble_cnt_four", 160'(bcnt), 160'd4);
        a.v = 1'b1;
        stall = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 65533; i++) @(posedge clk);
        #1;
        bcnt_model = 16'hFFFF;
        check("bubble_cnt_sat_reach", 160'(bcnt), 160'hFFFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, a);
        model = '0;
`endif

        // Random mix of stall, flush and loads.
        for (int i = 0; i < 200; i++) begin
            r = entry_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            r.rsa = 5'($urandom_range(0, 3));
            r.rta = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
